r22_sdf_ctrl: RTL and testbench
===============================

Name: r22_sdf_ctrl

Overview:
- Sequencer for the 16-point radix-2^2 single-path delay-feedback (SDF) FFT pipeline.
- The pipeline has four butterfly stages (BF2I, BF2II, BF2I, BF2II) with feedback delay lines of depth 8, 4, 2 and 1, plus one twiddle multiplier between stage 1 and stage 2.
- This block does four things:
  - accepts the input sample stream with a frame handshake;
  - drives the delay-line enables and per-stage butterfly/rotation selects;
  - generates twiddle ROM addresses;
  - flushes the pipeline after the last frame and flags output samples.
- Delay lines clear whenever their enable is low, so this block must hold the enable high continuously across a frame and its flush.

Parameters:
- STAGE_LAT, 1, register stages at the output of each butterfly stage.
- MULT_LAT, 2, latency of the twiddle multiplier (stage 1 to stage 2).
- TW_AW, 4, twiddle ROM address width; exponents 0..9 of W16.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input sample valid.
- in_sof  in  1  first sample of a frame; qualified by in_valid.
- in_ready  out  1  controller accepts a sample this cycle.
- dline_en  out  1  common enable for all delay lines.
- zero_in  out  1  datapath substitutes 0 for the input sample (flush).
- bf_sel  out  4  bf_sel[k]=1: stage k butterflies; 0: stage k fills its delay line.
- rot_sel  out  2  -j rotation select; bit0 for stage 1, bit1 for stage 3.
- tw_addr  out  TW_AW  twiddle exponent for the multiplier input sample.
- tw_en  out  1  multiplier enable.
- out_valid  out  1  pipeline output carries a real FFT bin.
- out_sof  out  1  first bin of an output frame.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, cnt=0, valid/sof history pipes cleared.
  - Every output is 0 while rst is high, including in_ready.
  - in_ready=1 from the first cycle after rst falls.
  - Reset mid-frame or mid-flush aborts immediately; dline_en=0 also clears the datapath.
- Accept: a sample is accepted when in_valid & in_ready.
  - in_valid while in_ready=0 is ignored and does not set err.
- cnt: 4-bit index of the sample at the pipeline input in this cycle.
  - 0 on the accepted in_sof; increments by 1 mod 16 every cycle in RUN and FLUSH.
- States:
  - IDLE: in_ready=1, dline_en=0. Accepted in_sof -> RUN with cnt=0. Accepted sample without in_sof -> err pulse, stay IDLE.
  - RUN: dline_en=1, zero_in=0, in_ready=1.
    - in_valid must be high every cycle.
    - in_sof must coincide exactly with cnt==0; in_sof at cnt!=0 -> err, go to IDLE.
    - in_valid low at cnt!=0 (mid-frame gap) -> err, go to IDLE; dline_en drops next cycle, so delay lines clear.
    - in_valid low at cnt==0 -> FLUSH.
  - FLUSH: dline_en=1, zero_in=1.
    - in_ready=1 only when cnt==0.
    - Accepted in_sof at cnt==0 -> RUN (back-to-back resume, zero_in=0 that cycle).
    - After 21 flush cycles (LAT_TOT with default parameters) with no resume -> IDLE.
- Stage timing: stage k sees sample index m_k = (cnt - d_k) mod 16.
  - d_0 = 0, d_1 = STAGE_LAT, d_2 = 2*STAGE_LAT + MULT_LAT, d_3 = 3*STAGE_LAT + MULT_LAT.
  - bf_sel[k] = bit (3-k) of m_k.
  - rot_sel[0] = (m_1[3:2] == 2'b11); rot_sel[1] = (m_3[1:0] == 2'b11).
- Twiddle:
  - m = (cnt - 2*STAGE_LAT) mod 16.
  - tw_addr = (m[3] + 2*m[2]) * m[1:0], range 0..9.
  - tw_en=1 in RUN/FLUSH, else 0 and tw_addr=0.
- Control outputs are registered and aligned to the cycle in which the corresponding sample is at that stage. They hold their last value when dline_en=0.
- Output flags:
  - LAT_TOT = 15 + 4*STAGE_LAT + MULT_LAT (21 with defaults).
  - out_valid = (accepted, non-zero-fill sample flag) delayed LAT_TOT cycles.
  - out_sof = accepted in_sof delayed LAT_TOT cycles.
- Simultaneous events:
  - rst has priority over everything.
  - An err condition in the same cycle as a valid in_sof resolves to err and IDLE.

Test Plan:
- Reset: assert rst 3 cycles during RUN -> all outputs 0; in_ready=1 the cycle after release; no out_valid for 25 cycles.
- Single frame: in_sof at t0, 16 continuous samples -> FLUSH at t0+16; out_sof at t0+21; out_valid high t0+21..t0+36; busy low from t0+37.
- Controls, one frame, defaults:
  - bf_sel[0]=0 for cnt 0..7 and 1 for 8..15.
  - rot_sel[0]=1 for m_1 = 12..15.
  - tw_addr for m = 6 / 13 / 15 = 4 / 3 / 9.
- Back-to-back: second in_sof exactly at t0+16 -> dline_en never drops; out_valid continuous for 32 cycles from t0+21, out_sof at t0+21 and t0+37.
- Mid-frame gap: in_valid low at cnt=5 -> err pulse, state IDLE, dline_en=0 next cycle, no out_valid for that frame.
- Misaligned in_sof at cnt=9 -> err pulse, IDLE. Sample with in_valid=1, in_sof=0 in IDLE -> err, stays IDLE.

Source files
------------

// File: rtl/r22_sdf_ctrl.sv
`default_nettype none
// ============================================================================
// Module : r22_sdf_ctrl
// Sequencer for a 16-point radix-2^2 SDF FFT: input handshake, stage selects,
// twiddle addresses, pipeline flush and output-bin flags.
// Rev    : 1.0  initial release
// ============================================================================
module r22_sdf_ctrl #(
  parameter int STAGE_LAT = 1,
  parameter int MULT_LAT  = 2,
  parameter int TW_AW     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic             dline_en,
  output logic             zero_in,
  output logic [3:0]       bf_sel,
  output logic [1:0]       rot_sel,
  output logic [TW_AW-1:0] tw_addr,
  output logic             tw_en,
  output logic             out_valid,
  output logic             out_sof,
  output logic             busy,
  output logic             err
);

  localparam int              C_LAT_TOT = 15 + 4*STAGE_LAT + MULT_LAT;
  localparam int              C_FW      = $clog2(C_LAT_TOT + 1);
  localparam logic [3:0]      C_D1      = 4'(STAGE_LAT % 16);
  localparam logic [3:0]      C_D2      = 4'((2*STAGE_LAT + MULT_LAT) % 16);
  localparam logic [3:0]      C_D3      = 4'((3*STAGE_LAT + MULT_LAT) % 16);
  localparam logic [3:0]      C_DTW     = 4'((2*STAGE_LAT) % 16);
  localparam logic [C_FW-1:0] C_FLAST   = C_FW'(C_LAT_TOT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                r_state, w_next;
  logic [3:0]            r_cnt, w_idx;
  logic [C_FW-1:0]       r_fcnt, w_fnext;
  logic [C_LAT_TOT-1:0]  r_vpipe, r_spipe;
  logic                  w_rdy, w_acc, w_act, w_zero, w_vflag, w_sflag, w_err, w_abort;
  logic [3:0]            w_m1, w_m2, w_m3, w_mt, w_tw4;

  // w_idx is the index of the sample (or zero fill) entering the pipeline this
  // cycle; every registered control below is derived from it one cycle ahead.
  always_comb begin
    w_rdy   = (r_state != S_FLUSH) || (r_cnt == 4'd0);
    w_acc   = in_valid && w_rdy;
    w_idx   = r_cnt;
    w_act   = 1'b0;
    w_zero  = 1'b0;
    w_vflag = 1'b0;
    w_sflag = 1'b0;
    w_err   = 1'b0;
    w_abort = 1'b0;
    w_next  = r_state;
    w_fnext = r_fcnt;
    case (r_state)
      S_IDLE: begin
        if (w_acc && in_sof) begin
          w_act = 1'b1; w_idx = 4'd0; w_vflag = 1'b1; w_sflag = 1'b1; w_next = S_RUN;
        end else if (w_acc) begin
          w_err = 1'b1;
        end
      end
      S_RUN: begin
        if (in_valid && (in_sof == (r_cnt == 4'd0))) begin
          w_act = 1'b1; w_vflag = 1'b1; w_sflag = in_sof;
        end else if (!in_valid && (r_cnt == 4'd0)) begin
          w_act = 1'b1; w_zero = 1'b1; w_next = S_FLUSH; w_fnext = C_FW'(1);
        end else begin
          w_err = 1'b1; w_abort = 1'b1; w_next = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (w_acc && in_sof) begin
          w_act = 1'b1; w_vflag = 1'b1; w_sflag = 1'b1; w_next = S_RUN;
        end else begin
          w_act  = 1'b1;
          w_zero = 1'b1;
          w_err  = w_acc;
          if (r_fcnt == C_FLAST) w_next = S_IDLE;
          else                   w_fnext = r_fcnt + C_FW'(1);
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_m1  = w_idx - C_D1;
  assign w_m2  = w_idx - C_D2;
  assign w_m3  = w_idx - C_D3;
  assign w_mt  = w_idx - C_DTW;
  assign w_tw4 = {2'b00, w_mt[2], w_mt[3]} * {2'b00, w_mt[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_fcnt   <= '0;
      r_vpipe  <= '0;
      r_spipe  <= '0;
      dline_en <= 1'b0;
      zero_in  <= 1'b0;
      bf_sel   <= 4'd0;
      rot_sel  <= 2'd0;
      tw_addr  <= '0;
      tw_en    <= 1'b0;
      err      <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_fcnt   <= w_fnext;
      r_cnt    <= w_act ? w_idx + 4'd1 : 4'd0;
      dline_en <= w_act;
      tw_en    <= w_act;
      err      <= w_err;
      if (w_act) begin
        zero_in <= w_zero;
        bf_sel  <= {|(w_m3 & 4'b0001), |(w_m2 & 4'b0010), |(w_m1 & 4'b0100), w_idx[3]};
        rot_sel <= {(w_m3 & 4'b0011) == 4'b0011, (w_m1 & 4'b1100) == 4'b1100};
        tw_addr <= TW_AW'(w_tw4);
      end else begin
        tw_addr <= '0;
      end
      // An abort drops dline_en, which wipes every sample still in flight.
      if (w_abort) begin
        r_vpipe <= '0;
        r_spipe <= '0;
      end else begin
        r_vpipe <= {r_vpipe[C_LAT_TOT-2:0], w_vflag};
        r_spipe <= {r_spipe[C_LAT_TOT-2:0], w_sflag};
      end
    end
  end

  assign in_ready  = !rst && w_rdy;
  assign busy      = !rst && (r_state != S_IDLE);
  assign out_valid = r_vpipe[C_LAT_TOT-1];
  assign out_sof   = r_spipe[C_LAT_TOT-1];

endmodule
`default_nettype wire

// File: tb/tb_r22_sdf_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_r22_sdf_ctrl
// Self-checking bench for r22_sdf_ctrl against a time-based protocol model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_r22_sdf_ctrl;
  localparam int LAT = 21;
  localparam int D1 = 1, D2 = 4, D3 = 5, DTW = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1, in_valid = 1'b0, in_sof = 1'b0;
  logic       in_ready, dline_en, zero_in, tw_en, out_valid, out_sof, busy, err;
  logic [3:0] bf_sel, tw_addr;
  logic [1:0] rot_sel;

  int n_vec = 0, n_err = 0, cyc = 0;

  // model: phase 0 idle, 1 frame, 2 flush; indices come from absolute time
  int   m_phase = 0, m_t0 = 0, m_tf = 0;
  bit   m_dline, m_zero, m_twen, m_ov, m_os, m_busy, m_err, m_rdy;
  bit [3:0] m_bf, m_tw;
  bit [1:0] m_rot;
  bit   pv[LAT], ps[LAT];

  r22_sdf_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
    .dline_en(dline_en), .zero_in(zero_in), .bf_sel(bf_sel), .rot_sel(rot_sel),
    .tw_addr(tw_addr), .tw_en(tw_en), .out_valid(out_valid), .out_sof(out_sof),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int mod16(input int x);
    return ((x % 16) + 16) % 16;
  endfunction

  function automatic int tw_of(input int m);
    return (((m / 8) % 2) + 2 * ((m / 4) % 2)) * (m % 4);
  endfunction

  task automatic tick(input bit v, input bit s, input bit r);
    int idx;
    bit act, zero, vf, sf, e, ab, acc;
    in_valid = v; in_sof = s; rst = r;
    idx = (m_phase == 0) ? 0 : mod16(cyc - m_t0);
    acc = v && ((m_phase != 2) || (idx == 0));
    act = 0; zero = 0; vf = 0; sf = 0; e = 0; ab = 0;
    if (r) begin
      m_phase = 0; m_dline = 0; m_zero = 0; m_twen = 0; m_err = 0;
      m_bf = 0; m_rot = 0; m_tw = 0;
      for (int i = 0; i < LAT; i++) begin pv[i] = 0; ps[i] = 0; end
    end else begin
      case (m_phase)
        0: if (acc && s) begin act = 1; vf = 1; sf = 1; m_t0 = cyc; m_phase = 1; end
           else if (acc) e = 1;
        1: if (v && (s == (idx == 0))) begin
             act = 1; vf = 1; sf = s;
             if (s) m_t0 = cyc;
           end else if (!v && idx == 0) begin
             act = 1; zero = 1; m_tf = cyc; m_phase = 2;
           end else begin
             e = 1; ab = 1; m_phase = 0;
           end
        default: if (acc && s) begin act = 1; vf = 1; sf = 1; m_t0 = cyc; m_phase = 1; end
           else begin
             act = 1; zero = 1; e = acc;
             if (cyc - m_tf == LAT - 1) m_phase = 0;
           end
      endcase
      m_err = e; m_dline = act; m_twen = act;
      if (act) begin
        m_zero = zero;
        m_bf[0] = mod16(idx) / 8 % 2 == 1;
        m_bf[1] = mod16(idx - D1) / 4 % 2 == 1;
        m_bf[2] = mod16(idx - D2) / 2 % 2 == 1;
        m_bf[3] = mod16(idx - D3) % 2 == 1;
        m_rot[0] = mod16(idx - D1) >= 12;
        m_rot[1] = mod16(idx - D3) % 4 == 3;
        m_tw = 4'(tw_of(mod16(idx - DTW)));
      end else m_tw = 0;
      if (ab) begin
        for (int i = 0; i < LAT; i++) begin pv[i] = 0; ps[i] = 0; end
      end else begin
        for (int i = 0; i < LAT - 1; i++) begin pv[i] = pv[i+1]; ps[i] = ps[i+1]; end
        pv[LAT-1] = vf; ps[LAT-1] = sf;
      end
    end
    @(posedge clk); @(negedge clk);
    cyc++;
    m_ov = pv[0]; m_os = ps[0];
    m_busy = !r && (m_phase != 0);
    m_rdy = !r && ((m_phase != 2) || (mod16(cyc - m_t0) == 0));
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1);
      n_vec++;
      if ({dline_en, zero_in, bf_sel, rot_sel, tw_addr, tw_en, out_valid, out_sof, busy, err, in_ready} !== '0) begin
        n_err++; $display("FAIL reset_zero cyc=%0d got=%b exp=0", cyc,
          {dline_en, zero_in, bf_sel, rot_sel, tw_addr, tw_en, out_valid, out_sof, busy, err, in_ready});
      end
    end
    tick(1, 1, 0);
    for (int i = 0; i < 5; i++) tick(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1);
      n_vec++;
      if ({dline_en, zero_in, bf_sel, rot_sel, tw_addr, tw_en, out_valid, out_sof, busy, err, in_ready} !== '0) begin
        n_err++; $display("FAIL reset_midrun cyc=%0d got=%b exp=0", cyc,
          {dline_en, zero_in, bf_sel, rot_sel, tw_addr, tw_en, out_valid, out_sof, busy, err, in_ready});
      end
    end
    rst = 0; #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready cyc=%0d got=%b exp=1", cyc, in_ready); end
    for (int i = 0; i < 25; i++) begin
      tick(0, 0, 0);
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_ov cyc=%0d got=%b exp=0", cyc, out_valid); end
    end
  endtask

  task automatic test_single_frame();
    int t0;
    tick(0, 0, 0);
    t0 = cyc;
    tick(1, 1, 0);
    for (int i = 1; i < 16; i++) tick(1, 0, 0);
    for (int i = 0; i < 26; i++) begin
      tick(0, 0, 0);
      n_vec++;
      if (out_valid !== ((cyc >= t0 + 21) && (cyc <= t0 + 36))) begin
        n_err++; $display("FAIL frame_ov cyc=%0d got=%b exp=%b", cyc, out_valid, (cyc >= t0 + 21) && (cyc <= t0 + 36));
      end
      n_vec++;
      if (out_sof !== (cyc == t0 + 21)) begin
        n_err++; $display("FAIL frame_osof cyc=%0d got=%b exp=%b", cyc, out_sof, cyc == t0 + 21);
      end
      n_vec++;
      if (busy !== (cyc <= t0 + 36)) begin
        n_err++; $display("FAIL frame_busy cyc=%0d got=%b exp=%b", cyc, busy, cyc <= t0 + 36);
      end
      n_vec++;
      if (zero_in !== m_zero) begin n_err++; $display("FAIL frame_zero cyc=%0d got=%b exp=%b", cyc, zero_in, m_zero); end
    end
  endtask

  task automatic test_controls();
    int t0, k;
    t0 = cyc;
    tick(1, 1, 0);
    for (int i = 1; i < 40; i++) begin
      k = cyc - t0 - 1;
      if (k < 16) begin
        n_vec++;
        if (bf_sel[0] !== (k >= 8)) begin n_err++; $display("FAIL ctl_bf0 cyc=%0d got=%b exp=%b", cyc, bf_sel[0], k >= 8); end
        n_vec++;
        if (rot_sel[0] !== (mod16(k - 1) >= 12)) begin
          n_err++; $display("FAIL ctl_rot0 cyc=%0d got=%b exp=%b", cyc, rot_sel[0], mod16(k - 1) >= 12);
        end
      end
      if (k == 8)  begin n_vec++; if (tw_addr !== 4'd4) begin n_err++; $display("FAIL ctl_tw6 got=%0d exp=4", tw_addr); end end
      if (k == 15) begin n_vec++; if (tw_addr !== 4'd3) begin n_err++; $display("FAIL ctl_tw13 got=%0d exp=3", tw_addr); end end
      if (k == 17) begin n_vec++; if (tw_addr !== 4'd9) begin n_err++; $display("FAIL ctl_tw15 got=%0d exp=9", tw_addr); end end
      n_vec++;
      if ({bf_sel, rot_sel, tw_addr, tw_en} !== {m_bf, m_rot, m_tw, m_twen}) begin
        n_err++; $display("FAIL ctl_model cyc=%0d got=%b exp=%b", cyc, {bf_sel, rot_sel, tw_addr, tw_en}, {m_bf, m_rot, m_tw, m_twen});
      end
      tick(i < 16, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    t0 = cyc;
    for (int f = 0; f < 2; f++) begin
      tick(1, 1, 0);
      for (int i = 1; i < 16; i++) tick(1, 0, 0);
    end
    while (cyc < t0 + 58) begin
      n_vec++;
      if (cyc >= t0 + 1 && cyc <= t0 + 53 && dline_en !== 1'b1) begin
        n_err++; $display("FAIL b2b_dline cyc=%0d got=%b exp=1", cyc, dline_en);
      end
      n_vec++;
      if (out_valid !== ((cyc >= t0 + 21) && (cyc <= t0 + 52))) begin
        n_err++; $display("FAIL b2b_ov cyc=%0d got=%b exp=%b", cyc, out_valid, (cyc >= t0 + 21) && (cyc <= t0 + 52));
      end
      n_vec++;
      if (out_sof !== (cyc == t0 + 21 || cyc == t0 + 37)) begin
        n_err++; $display("FAIL b2b_osof cyc=%0d got=%b exp=%b", cyc, out_sof, cyc == t0 + 21 || cyc == t0 + 37);
      end
      tick(0, 0, 0);
    end
  endtask

  task automatic test_errors();
    tick(1, 1, 0);
    for (int i = 1; i < 5; i++) tick(1, 0, 0);
    tick(0, 0, 0);
    n_vec++;
    if ({err, busy, dline_en} !== 3'b100) begin n_err++; $display("FAIL gap_err cyc=%0d got=%b exp=100", cyc, {err, busy, dline_en}); end
    for (int i = 0; i < 30; i++) begin
      tick(0, 0, 0);
      n_vec++;
      if ({out_valid, err} !== 2'b00) begin n_err++; $display("FAIL gap_quiet cyc=%0d got=%b exp=00", cyc, {out_valid, err}); end
    end
    tick(1, 1, 0);
    for (int i = 1; i < 9; i++) tick(1, 0, 0);
    tick(1, 1, 0);
    n_vec++;
    if ({err, busy} !== 2'b10) begin n_err++; $display("FAIL missof_err cyc=%0d got=%b exp=10", cyc, {err, busy}); end
    tick(1, 0, 0);
    n_vec++;
    if ({err, busy, dline_en} !== 3'b100) begin n_err++; $display("FAIL idle_stray cyc=%0d got=%b exp=100", cyc, {err, busy, dline_en}); end
    tick(0, 0, 0);
    n_vec++;
    if (err !== 1'b0) begin n_err++; $display("FAIL err_pulse cyc=%0d got=%b exp=0", cyc, err); end
    for (int i = 0; i < 25; i++) tick(0, 0, 0);
  endtask

  task automatic test_random();
    int idx, r;
    bit v, s, rr;
    for (int n = 0; n < 3000; n++) begin
      idx = mod16(cyc - m_t0);
      r = $urandom_range(0, 199);
      v = 0; s = 0; rr = 0;
      if (r < 1) rr = 1;
      else case (m_phase)
        0: if (r < 60) begin v = 1; s = 1; end else if (r < 66) v = 1;
        1: if (idx == 0) begin
             if (r < 100) begin v = 1; s = 1; end else if (r < 192) v = 0; else v = 1;
           end else if (r < 195) v = 1;
           else if (r < 197) begin v = 1; s = 1; end
        default: if (idx == 0 && r < 80) begin v = 1; s = 1; end else if (r < 90) v = 1;
      endcase
      tick(v, s, rr);
      n_vec++;
      if (in_ready !== m_rdy) begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, in_ready, m_rdy); end
      n_vec++;
      if ({dline_en, zero_in, tw_en} !== {m_dline, m_zero, m_twen}) begin
        n_err++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", cyc, {dline_en, zero_in, tw_en}, {m_dline, m_zero, m_twen});
      end
      n_vec++;
      if ({bf_sel, rot_sel, tw_addr} !== {m_bf, m_rot, m_tw}) begin
        n_err++; $display("FAIL rnd_sel cyc=%0d got=%b exp=%b", cyc, {bf_sel, rot_sel, tw_addr}, {m_bf, m_rot, m_tw});
      end
      n_vec++;
      if ({out_valid, out_sof} !== {m_ov, m_os}) begin
        n_err++; $display("FAIL rnd_out cyc=%0d got=%b exp=%b", cyc, {out_valid, out_sof}, {m_ov, m_os});
      end
      n_vec++;
      if ({busy, err} !== {m_busy, m_err}) begin
        n_err++; $display("FAIL rnd_stat cyc=%0d got=%b exp=%b", cyc, {busy, err}, {m_busy, m_err});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_controls();
    test_back_to_back();
    test_errors();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
